// File: rtl/serial_slave_port.sv
// serial_slave_port
// Slave endpoint of the serial bus. It decodes a serial control frame made of
// a start bit, an rw bit and the address sent MSB first. After the frame it
// either deserializes write words into local memory or serializes read words
// back to the master on rD. Every output is registered. Memory contents are
// not reset.
module serial_slave_port #(
  parameter int DATA_WIDTH = 8,
  parameter int MEM_DEPTH  = 16,
  parameter int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
  input  logic clk,
  input  logic rst,
  input  logic control,
  input  logic wD,
  input  logic valid,
  input  logic last,
  output logic rD,
  output logic ready
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int CW = $clog2(ADDR_WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CTRL   = 3'd1,
    WRITE  = 3'd2,
    RFETCH = 3'd3,
    RSEND  = 3'd4
  } state_t;

  state_t                  state_r, state_s;
  logic [CW-1:0]           ctrl_cnt_r, ctrl_cnt_s;
  logic                    rw_r, rw_s;
  logic [ADDR_WIDTH-1:0]   addr_r, addr_s;
  logic [BW-1:0]           bit_cnt_r, bit_cnt_s;
  logic [DATA_WIDTH-1:0]   rx_r, rx_s;
  logic [DATA_WIDTH-1:0]   tx_r, tx_s;
  logic                    ready_r, ready_s;
  logic                    rd_r, rd_s;
  logic                    mem_we_s;
  logic [DATA_WIDTH-1:0]   mem_wdata_s;
  logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

  // Next word address. It wraps from the top of memory back to zero.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a);
    if (a == ADDR_WIDTH'(MEM_DEPTH - 1)) begin
      next_addr = '0;
    end else begin
      next_addr = a + ADDR_WIDTH'(1);
    end
  endfunction

  // Next-state logic: frame decoding, word shifting and the memory write strobe.
  always_comb begin
    state_s     = state_r;
    ctrl_cnt_s  = ctrl_cnt_r;
    rw_s        = rw_r;
    addr_s      = addr_r;
    bit_cnt_s   = bit_cnt_r;
    rx_s        = rx_r;
    tx_s        = tx_r;
    mem_we_s    = 1'b0;
    mem_wdata_s = rx_r;

    case (state_r)
      IDLE: begin
        if (control) begin
          state_s    = CTRL;
          ctrl_cnt_s = '0;
          bit_cnt_s  = '0;
        end else begin
          state_s = IDLE;
        end
      end

      CTRL: begin
        // The first CTRL cycle carries rw. The following cycles carry the address bits.
        if (ctrl_cnt_r == '0) begin
          rw_s = control;
        end else begin
          addr_s = ADDR_WIDTH'({addr_r, control});
        end
        ctrl_cnt_s = ctrl_cnt_r + CW'(1);
        if (ctrl_cnt_r == CW'(ADDR_WIDTH)) begin
          state_s   = rw_r ? WRITE : RFETCH;
          bit_cnt_s = '0;
        end else begin
          state_s = CTRL;
        end
      end

      WRITE: begin
        if (valid) begin
          rx_s = {rx_r[DATA_WIDTH-2:0], wD};
          if (bit_cnt_r == BW'(DATA_WIDTH - 1)) begin
            mem_we_s    = 1'b1;
            mem_wdata_s = {rx_r[DATA_WIDTH-2:0], wD};
            addr_s      = next_addr(addr_r);
            bit_cnt_s   = '0;
            state_s     = last ? IDLE : WRITE;
          end else if (last) begin
            // The burst ends mid-word. The partial word is dropped.
            bit_cnt_s = '0;
            state_s   = IDLE;
          end else begin
            bit_cnt_s = bit_cnt_r + BW'(1);
          end
        end else begin
          state_s = WRITE;
        end
      end

      RFETCH: begin
        tx_s      = mem[addr_r];
        bit_cnt_s = '0;
        state_s   = RSEND;
      end

      RSEND: begin
        if (valid) begin
          tx_s = {tx_r[DATA_WIDTH-2:0], 1'b0};
          if (bit_cnt_r == BW'(DATA_WIDTH - 1)) begin
            bit_cnt_s = '0;
            if (last) begin
              state_s = IDLE;
            end else begin
              addr_s  = next_addr(addr_r);
              state_s = RFETCH;
            end
          end else if (last) begin
            bit_cnt_s = '0;
            state_s   = IDLE;
          end else begin
            bit_cnt_s = bit_cnt_r + BW'(1);
          end
        end else begin
          state_s = RSEND;
        end
      end

      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Output values for the next cycle. Registering them keeps rD and ready glitch-free.
  always_comb begin
    ready_s = 1'b1;
    rd_s    = 1'b0;
    if (state_s == RFETCH) begin
      ready_s = 1'b0;
    end else begin
      ready_s = 1'b1;
    end
    if (state_s == RSEND) begin
      rd_s = tx_s[DATA_WIDTH-1];
    end else begin
      rd_s = 1'b0;
    end
  end

  // State and datapath registers, cleared by the asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      ctrl_cnt_r <= '0;
      rw_r       <= 1'b0;
      addr_r     <= '0;
      bit_cnt_r  <= '0;
      rx_r       <= '0;
      tx_r       <= '0;
      ready_r    <= 1'b1;
      rd_r       <= 1'b0;
    end else begin
      state_r    <= state_s;
      ctrl_cnt_r <= ctrl_cnt_s;
      rw_r       <= rw_s;
      addr_r     <= addr_s;
      bit_cnt_r  <= bit_cnt_s;
      rx_r       <= rx_s;
      tx_r       <= tx_s;
      ready_r    <= ready_s;
      rd_r       <= rd_s;
    end
  end

  // Local memory write port. The contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem[addr_r] <= mem_wdata_s;
    end
  end

  assign rD    = rd_r;
  assign ready = ready_r;

endmodule
